// File: rtl/ov7670_capture_pkg.sv
// Shared camera definitions for the OV7670 capture path: FSM state encoding,
// default frame geometry and RGB565 field positions.
package ov7670_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_SKIP    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

endpackage

// File: rtl/ov7670_edge_det.sv
// Registers one camera sync line and flags its rising/falling edges,
// comparing the registered copy against its previous-cycle value.
module ov7670_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= sig;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 byte-stream to RGB565 pixel capture with linear write addressing.
// Optional 2x2 decimation when CAPTURE_DECIMATE_EN is defined.
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int ADDR_W      = 19,
  parameter int SKIP_FRAMES = 2
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              cfg_done,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              capturing
);

`ifdef CAPTURE_DECIMATE_EN
  localparam int OUT_PIX = (H_ACTIVE / 2) * (V_ACTIVE / 2);
`else
  localparam int OUT_PIX = H_ACTIVE * V_ACTIVE;
`endif
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(OUT_PIX - 1);

  logic vs_q, vs_rise, vs_fall;
  logic hr_q, hr_rise, hr_fall;
  logic [7:0] d_q, hi_q;
  state_t state, state_nxt;
  logic [7:0] skip_cnt;
  logic phase, hi_phase, keep, addr_full, err_acc;
  logic [15:0] col_cnt, line_cnt;
  logic [ADDR_W-1:0] addr_cnt;

  ov7670_edge_det u_vs (.clk(pclk), .rst_n(rst_n), .sig(vsync), .q(vs_q), .rise(vs_rise), .fall(vs_fall));
  ov7670_edge_det u_hr (.clk(pclk), .rst_n(rst_n), .sig(href),  .q(hr_q), .rise(hr_rise), .fall(hr_fall));

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) d_q <= 8'd0;
    else        d_q <= d;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!cfg_done) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = ST_SYNC;
        ST_SYNC:    if (vs_rise) state_nxt = (SKIP_FRAMES == 0) ? ST_CAPTURE : ST_SKIP;
        ST_SKIP:    if (vs_rise && skip_cnt == 8'(SKIP_FRAMES - 1)) state_nxt = ST_CAPTURE;
        ST_CAPTURE: state_nxt = ST_CAPTURE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  assign capturing = (state == ST_CAPTURE);

  // A fresh HREF rise always realigns to the high byte.
  assign hi_phase = ~phase | hr_rise;

`ifdef CAPTURE_DECIMATE_EN
  assign keep = ~col_cnt[0] & ~line_cnt[0];
`else
  assign keep = 1'b1;
`endif

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt   <= 8'd0;
      phase      <= 1'b0;
      hi_q       <= 8'd0;
      col_cnt    <= 16'd0;
      line_cnt   <= 16'd0;
      addr_cnt   <= '0;
      addr_full  <= 1'b0;
      err_acc    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 16'd0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;

      if (state == ST_SKIP) begin
        if (vs_rise) skip_cnt <= skip_cnt + 8'd1;
      end else begin
        skip_cnt <= 8'd0;
      end

      if (state != ST_CAPTURE || !cfg_done || vs_fall) begin
        phase     <= 1'b0;
        col_cnt   <= 16'd0;
        line_cnt  <= 16'd0;
        addr_cnt  <= '0;
        addr_full <= 1'b0;
        err_acc   <= 1'b0;
      end else if (vs_rise) begin
        frame_done <= 1'b1;
        frame_err  <= err_acc | (line_cnt != 16'(V_ACTIVE));
      end else if (hr_q) begin
        if (hi_phase) begin
          hi_q  <= d_q;
          phase <= 1'b1;
        end else begin
          phase   <= 1'b0;
          col_cnt <= col_cnt + 16'd1;
          if (line_cnt >= 16'(V_ACTIVE)) begin
            err_acc <= 1'b1;
          end else if (keep) begin
            if (addr_full) begin
              err_acc <= 1'b1;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= addr_cnt;
              wr_data <= {hi_q, d_q};
              if (addr_cnt == ADDR_MAX) addr_full <= 1'b1;
              else                      addr_cnt  <= addr_cnt + 1'b1;
            end
          end
        end
      end else if (hr_fall) begin
        // A dangling high byte means the line was not a whole number of pixels.
        phase    <= 1'b0;
        col_cnt  <= 16'd0;
        line_cnt <= line_cnt + 16'd1;
        if (col_cnt != 16'(H_ACTIVE) || phase) err_acc <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a tiny 4x3 frame (4x4 when decimating).
module tb_ov7670_capture;

  localparam int H_T = 4;
`ifdef CAPTURE_DECIMATE_EN
  localparam int V_T = 4;
`else
  localparam int V_T = 3;
`endif
  localparam int AW = 19;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_done = 1'b0;
  logic vsync = 1'b0;
  logic href = 1'b0;
  logic [7:0] d = 8'd0;
  logic wr_en, frame_done, frame_err, capturing;
  logic [AW-1:0] wr_addr;
  logic [15:0] wr_data;

  ov7670_capture #(.H_ACTIVE(H_T), .V_ACTIVE(V_T), .ADDR_W(AW), .SKIP_FRAMES(2)) dut (
    .pclk(pclk), .rst_n(rst_n), .cfg_done(cfg_done), .vsync(vsync), .href(href), .d(d),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_err(frame_err), .capturing(capturing)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int fd_cnt = 0;
  int dbl_cnt = 0;
  logic prev_wr = 1'b0;
  logic [AW-1:0] a_log [0:255];
  logic [15:0]   d_log [0:255];

  always @(negedge pclk) begin
    if (wr_en) begin
      if (wr_cnt < 256) begin
        a_log[wr_cnt] = wr_addr;
        d_log[wr_cnt] = wr_data;
      end
      wr_cnt++;
    end
    if (wr_en && prev_wr) dbl_cnt++;
    if (frame_done) fd_cnt++;
    prev_wr = wr_en;
  end

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic settle();
    @(negedge pclk);
    #1;
  endtask

  task automatic send_line(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      d = 8'(base + i);
      tick();
    end
    href = 1'b0;
    d = 8'd0;
    repeat (4) tick();
  endtask

  task automatic send_vs();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic send_body(input int lines);
    for (int l = 0; l < lines; l++) send_line(2 * H_T, l * 2 * H_T);
  endtask

  task automatic test_reset();
    int s0, f0;
    rst_n = 1'b0;
    cfg_done = 1'b0;
    repeat (3) tick();
    #1;
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL reset_capturing got %0d exp 0", capturing); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0d exp 0", wr_en); end
    checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got %0d exp 0", wr_addr); end
    checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_data got %h exp 0000", wr_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0d exp 0", frame_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %0d exp 0", frame_err); end
    rst_n = 1'b1;
    tick();
    s0 = wr_cnt; f0 = fd_cnt;
    send_vs(); send_body(V_T); send_vs(); send_body(V_T); send_vs();
    settle();
    checks++; if (wr_cnt - s0 !== 0) begin errors++; $display("FAIL nocfg_writes got %0d exp 0", wr_cnt - s0); end
    checks++; if (fd_cnt - f0 !== 0) begin errors++; $display("FAIL nocfg_frame_done got %0d exp 0", fd_cnt - f0); end
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL nocfg_capturing got %0d exp 0", capturing); end
  endtask

  // Brings the capture up from IDLE: one sync frame edge, two skipped frames,
  // then one captured frame; checks the skipped frames are silent.
  task automatic run_to_capture(input string tag, output int s0, output int f0);
    cfg_done = 1'b1;
    tick();
    s0 = wr_cnt; f0 = fd_cnt;
    send_vs(); send_body(V_T); send_vs(); send_body(V_T);
    settle();
    checks++; if (wr_cnt - s0 !== 0) begin errors++; $display("FAIL %s_skip_writes got %0d exp 0", tag, wr_cnt - s0); end
    checks++; if (fd_cnt - f0 !== 0) begin errors++; $display("FAIL %s_skip_frame_done got %0d exp 0", tag, fd_cnt - f0); end
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL %s_skip_capturing got %0d exp 0", tag, capturing); end
    send_vs();
  endtask

  task automatic check_full_frame(input string tag, input int s0, input int f0);
    checks++; if (wr_cnt - s0 !== 12) begin errors++; $display("FAIL %s_writes got %0d exp 12", tag, wr_cnt - s0); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (a_log[s0 + i] !== AW'(i) || d_log[s0 + i] !== {8'(2 * i), 8'(2 * i + 1)}) begin
        errors++;
        $display("FAIL %s_pixel%0d got addr %0d data %h exp addr %0d data %h", tag, i,
                 a_log[s0 + i], d_log[s0 + i], i, {8'(2 * i), 8'(2 * i + 1)});
      end
    end
    checks++; if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL %s_frame_done got %0d exp 1", tag, fd_cnt - f0); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL %s_frame_err got %0d exp 0", tag, frame_err); end
  endtask

  task automatic test_capture();
    int s0, f0;
    run_to_capture("cap", s0, f0);
    send_body(V_T);
    settle();
    checks++; if (capturing !== 1'b1) begin errors++; $display("FAIL cap_capturing got %0d exp 1", capturing); end
    send_vs();
    settle();
    check_full_frame("cap", s0, f0);
    checks++; if (dbl_cnt !== 0) begin errors++; $display("FAIL wr_en_single_cycle got %0d exp 0", dbl_cnt); end
  endtask

  task automatic test_odd_line();
    int s0, f0;
    s0 = wr_cnt; f0 = fd_cnt;
    send_line(9, 0);
    send_line(8, 8);
    send_line(8, 16);
    send_vs();
    settle();
    checks++; if (wr_cnt - s0 !== 12) begin errors++; $display("FAIL odd_writes got %0d exp 12", wr_cnt - s0); end
    checks++; if (d_log[s0 + 3] !== 16'h0607) begin errors++; $display("FAIL odd_last_px got %h exp 0607", d_log[s0 + 3]); end
    checks++; if (a_log[s0 + 4] !== AW'(4) || d_log[s0 + 4] !== 16'h0809) begin
      errors++; $display("FAIL odd_next_line got addr %0d data %h exp addr 4 data 0809", a_log[s0 + 4], d_log[s0 + 4]); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL odd_frame_err got %0d exp 1", frame_err); end
    checks++; if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL odd_frame_done got %0d exp 1", fd_cnt - f0); end
    s0 = wr_cnt; f0 = fd_cnt;
    send_body(V_T);
    send_vs();
    settle();
    check_full_frame("clean", s0, f0);
  endtask

  task automatic test_extra_line();
    int s0, f0;
    s0 = wr_cnt; f0 = fd_cnt;
    send_body(V_T + 1);
    send_vs();
    settle();
    checks++; if (wr_cnt - s0 !== 12) begin errors++; $display("FAIL extra_writes got %0d exp 12", wr_cnt - s0); end
    checks++; if (d_log[s0 + 11] !== 16'h1617) begin errors++; $display("FAIL extra_last_px got %h exp 1617", d_log[s0 + 11]); end
    checks++; if (wr_addr !== AW'(11)) begin errors++; $display("FAIL extra_wr_addr got %0d exp 11", wr_addr); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL extra_frame_err got %0d exp 1", frame_err); end
    checks++; if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL extra_frame_done got %0d exp 1", fd_cnt - f0); end
  endtask

  task automatic test_cfg_drop();
    int s0, f0;
    s0 = wr_cnt; f0 = fd_cnt;
    send_line(8, 0);
    for (int i = 8; i < 11; i++) begin
      href = 1'b1;
      d = 8'(i);
      tick();
    end
    cfg_done = 1'b0;
    href = 1'b0;
    d = 8'd0;
    repeat (4) tick();
    settle();
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL drop_capturing got %0d exp 0", capturing); end
    checks++; if (wr_cnt - s0 !== 5) begin errors++; $display("FAIL drop_writes got %0d exp 5", wr_cnt - s0); end
    checks++; if (a_log[s0 + 4] !== AW'(4) || d_log[s0 + 4] !== 16'h0809) begin
      errors++; $display("FAIL drop_px5 got addr %0d data %h exp addr 4 data 0809", a_log[s0 + 4], d_log[s0 + 4]); end
    send_vs();
    settle();
    checks++; if (fd_cnt - f0 !== 0) begin errors++; $display("FAIL drop_frame_done got %0d exp 0", fd_cnt - f0); end
    run_to_capture("recfg", s0, f0);
    send_body(V_T);
    send_vs();
    settle();
    check_full_frame("recfg", s0, f0);
  endtask

  task automatic test_decimate();
    int s0, f0;
    logic [15:0] exp_d [0:3];
    exp_d[0] = 16'h0001; exp_d[1] = 16'h0405; exp_d[2] = 16'h1011; exp_d[3] = 16'h1415;
    run_to_capture("dec", s0, f0);
    send_body(V_T);
    send_vs();
    settle();
    checks++; if (wr_cnt - s0 !== 4) begin errors++; $display("FAIL dec_writes got %0d exp 4", wr_cnt - s0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_log[s0 + i] !== AW'(i) || d_log[s0 + i] !== exp_d[i]) begin
        errors++;
        $display("FAIL dec_pixel%0d got addr %0d data %h exp addr %0d data %h", i,
                 a_log[s0 + i], d_log[s0 + i], i, exp_d[i]);
      end
    end
    checks++; if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL dec_frame_done got %0d exp 1", fd_cnt - f0); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL dec_frame_err got %0d exp 0", frame_err); end
  endtask

  initial begin
    test_reset();
`ifdef CAPTURE_DECIMATE_EN
    test_decimate();
`else
    test_capture();
    test_odd_line();
    test_extra_line();
    test_cfg_drop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Pixel-capture stage directly downstream of the OV7670 camera controller. It runs on the camera pixel clock and waits for register configuration to complete before doing anything. It then aligns to the camera's VSYNC/HREF timing and assembles the 8-bit byte stream into RGB565 pixels. Each pixel is presented with a linear frame-buffer write address, ready for a dual-clock frame buffer.

## Interface
Parameters:
- H_ACTIVE, 640: pixels per line from camera
- V_ACTIVE, 480: lines per frame from camera
- ADDR_W, 19: write-address width; must hold (output pixels per frame − 1)
- SKIP_FRAMES, 2: frames discarded after configuration completes (sensor settling)

Ports:
- pclk  in  1  camera pixel clock, the only clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_done  in  1  configuration-complete level from the camera controller
- vsync  in  1  camera VSYNC, high during vertical blanking
- href  in  1  camera HREF, high while line bytes are valid
- d  in  8  camera data byte
- wr_en  out  1  one-cycle pixel write strobe
- wr_addr  out  ADDR_W  linear pixel address, row-major, 0 = top-left
- wr_data  out  16  RGB565 pixel {first byte, second byte}
- frame_done  out  1  one-cycle pulse at the end of each complete captured frame
- frame_err  out  1  sticky per frame: line or pixel count mismatch in the last frame
- capturing  out  1  high in the CAPTURE state

## Operation
- Input register stage: vsync, href and d are registered on every pclk edge. All logic uses the registered copies (vs_q, hr_q, d_q) and the previous-cycle vs_q.
- FSM states: IDLE, SYNC, SKIP, CAPTURE.
  - IDLE: waits for cfg_done = 1, then goes to SYNC.
  - SYNC: waits for a vs_q rising edge (start of blanking), then goes to SKIP. If SKIP_FRAMES = 0, it goes straight to CAPTURE.
  - SKIP: counts vs_q rising edges. After SKIP_FRAMES edges, goes to CAPTURE.
  - CAPTURE: on a vs_q falling edge, clears the pixel counter (pix_cnt), line counter (line_cnt), byte phase and frame_err_acc. On a vs_q rising edge, ends the frame.
- cfg_done = 0 in any state, including mid-frame: next state is IDLE. A partial frame produces no frame_done, and the counters clear.
- Byte pairing:
  - While hr_q = 1 in CAPTURE, the phase bit toggles on every byte.
  - Phase 0 stores the high byte.
  - Phase 1 produces a pixel {hi, d_q}.
  - The phase resets to 0 on an hr_q falling edge, so a dangling odd byte is discarded.
- Line end (hr_q falling edge):
  - line_cnt increments.
  - If the pixel count for the line ≠ H_ACTIVE, frame_err_acc is set.
- Frame end:
  - If line_cnt ≠ V_ACTIVE, frame_err_acc is set.
  - frame_done pulses.
  - frame_err loads frame_err_acc and holds it until the next frame end.
- Address:
  - wr_addr increments after each written pixel.
  - Pixels whose address would exceed (output pixels − 1) are suppressed (no wr_en) and set frame_err_acc. The address saturates; it does not wrap.
- Lines beyond V_ACTIVE are suppressed in the same way.

## Timing
- Reset values: wr_en = 0, wr_addr = 0, wr_data = 0, frame_done = 0, frame_err = 0, capturing = 0, state = IDLE.
- Latency: the low byte on d at pclk edge k produces wr_en, wr_addr and wr_data valid after edge k+1. wr_en is high for exactly one cycle.
- wr_addr and wr_data are stable while wr_en = 1. They may change at any time when wr_en = 0.
- frame_done is asserted the cycle after the registered vsync rise is detected, i.e. 2 edges after vsync rises at the pin.
- capturing follows the registered state.
- The maximum write rate is one pixel per 2 pclk cycles. The consumer must accept a write on every strobe; there is no back-pressure.

## Configuration
- CAPTURE_DECIMATE_EN defined:
  - 2×2 decimation; only pixels with even column and even row are written.
  - Output frame is (H_ACTIVE/2)×(V_ACTIVE/2).
  - The address limit is computed from the halved size.
  - Error checks still use the full H_ACTIVE and V_ACTIVE.
- CAPTURE_DECIMATE_EN undefined: every pixel is written; output frame is H_ACTIVE×V_ACTIVE.

## Structure
- A shared camera package holds:
  - the state enum (IDLE/SYNC/SKIP/CAPTURE);
  - default H_ACTIVE/V_ACTIVE constants;
  - the RGB565 field positions (R[15:11], G[10:5], B[4:0]).
- One sub-module, ov7670_edge_det: registers vsync/href and outputs rise/fall pulses. It is instantiated once per signal.

## Test plan
- Reset with cfg_done = 0, then drive full frames → capturing = 0, no wr_en, no frame_done.
- cfg_done = 1, SKIP_FRAMES = 2, 4×3 test frame (H_ACTIVE = 4, V_ACTIVE = 3), bytes 0x00..0x17 → first 2 frames are silent. The third frame gives 12 writes, addr 0..11: data 0x0001, 0x0203, … 0x1617. frame_done pulses once; frame_err = 0.
- Line with 9 bytes (odd) → 4 pixels written, the last byte is dropped, frame_err = 1 after frame end. The next clean frame clears frame_err to 0.
- 4 lines in a V_ACTIVE = 3 frame → the 4th line produces no wr_en, wr_addr stays at 11, frame_err = 1.
- cfg_done deasserted mid-frame after 5 pixels → state goes to IDLE, no frame_done. Reasserting cfg_done re-runs SYNC and SKIP.
- CAPTURE_DECIMATE_EN, 4×4 frame → writes only at (0,0), (2,0), (0,2), (2,2), at addr 0..3.
